// File: rtl/button_scan_debounce_pkg.sv
// Shared defaults and helpers for the mole-hit button conditioner.
// Runs on the 1 kHz scan clock, so one cycle equals one millisecond.
package button_scan_debounce_pkg;

  localparam int NUM_BTN_DEF     = 4;
  localparam int DEBOUNCE_MS_DEF = 20;
  localparam int IDX_W_DEF       = 3;

  // Index of the lowest set bit; returns 0 when nothing is set.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    lowest_set = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_set = 3'(i);
    end
  endfunction

endpackage

// File: rtl/button_scan_debounce_if.sv
// Press-event handshake between the button conditioner and the game FSM.
interface button_scan_debounce_if
  import button_scan_debounce_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
);
  logic             evt_valid;
  logic [IDX_W-1:0] evt_idx;
  logic             evt_ack;
  logic             evt_overrun;

  modport master (output evt_valid, output evt_idx, output evt_overrun, input evt_ack);
  modport slave  (input evt_valid, input evt_idx, input evt_overrun, output evt_ack);
endinterface

// File: rtl/button_scan_debounce_ch.sv
// One button: 2-flop synchronizer, stability counter, debounced level and
// a registered one-cycle pulse on each accepted 0->1 transition.
module btn_debounce_ch #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk_1k,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);
  localparam int CNT_W = $clog2(DEBOUNCE_MS) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

  logic             meta_q, sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;

  // Any sample that agrees with the current level restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q;
        press_d = sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_1k or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      meta_q  <= raw_i;
      sync_q  <= meta_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;
endmodule

// File: rtl/button_scan_debounce.sv
// Debounces NUM_BTN raw buttons and queues one press event for the game FSM,
// flagging a sticky overrun whenever a press cannot be queued.
module button_scan_debounce
  import button_scan_debounce_pkg::*;
#(
  parameter int NUM_BTN     = NUM_BTN_DEF,
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF,
  parameter int IDX_W       = IDX_W_DEF
) (
  input  logic                  clk_1k,
  input  logic                  rst_n,
  input  logic [NUM_BTN-1:0]    btn_raw,
  output logic [NUM_BTN-1:0]    btn_level,
  output logic [NUM_BTN-1:0]    btn_press,
  button_scan_debounce_if.master evt
);
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_ch
      btn_debounce_ch #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_ch (
        .clk_1k  (clk_1k),
        .rst_n   (rst_n),
        .raw_i   (btn_raw[gi]),
        .level_o (btn_level[gi]),
        .press_o (btn_press[gi])
      );
    end
  endgenerate

  logic [7:0]       press_pad;
  logic             any_press, multi_press;
  logic [IDX_W-1:0] low_idx;

  assign press_pad   = 8'(btn_press);
  assign any_press   = |btn_press;
  assign multi_press = |(btn_press & (btn_press - NUM_BTN'(1)));
  assign low_idx     = IDX_W'(lowest_set(press_pad));

  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ovr_q, ovr_d;

  // Ack only matters while an entry is held; it frees the slot for a press
  // arriving in the same cycle.
  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    ovr_d   = ovr_q;
    if (!valid_q) begin
      if (any_press) begin
        valid_d = 1'b1;
        idx_d   = low_idx;
        if (multi_press) ovr_d = 1'b1;
      end
    end else if (!evt.evt_ack) begin
      if (any_press) ovr_d = 1'b1;
    end else if (!any_press) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      idx_d = low_idx;
      ovr_d = multi_press;
    end
  end

  always_ff @(posedge clk_1k or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      ovr_q   <= ovr_d;
    end
  end

  assign evt.evt_valid   = valid_q;
  assign evt.evt_idx     = idx_q;
  assign evt.evt_overrun = ovr_q;
endmodule

// File: tb/tb_button_scan_debounce.sv
// Directed bench for button_scan_debounce with DEBOUNCE_MS=4, NUM_BTN=4.
module tb_button_scan_debounce;
  localparam int NB = 4;

  logic          clk_1k = 1'b0;
  logic          rst_n;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  int            n_checks = 0;
  int            n_err    = 0;

  button_scan_debounce_if #(.IDX_W(3)) evt_if ();

  button_scan_debounce #(.NUM_BTN(NB), .DEBOUNCE_MS(4), .IDX_W(3)) dut (
    .clk_1k    (clk_1k),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_press (btn_press),
    .evt       (evt_if.master)
  );

  always #5 clk_1k = ~clk_1k;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_1k);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_evt(input string tag, input logic v, input logic [2:0] idx, input logic ovr);
    chk({tag, "_valid"}, 32'(evt_if.evt_valid), 32'(v));
    chk({tag, "_idx"}, 32'(evt_if.evt_idx), 32'(idx));
    chk({tag, "_ovr"}, 32'(evt_if.evt_overrun), 32'(ovr));
  endtask

  initial begin
    rst_n          = 1'b0;
    btn_raw        = '0;
    evt_if.evt_ack = 1'b0;
    step(2);
    chk("rst_level", 32'(btn_level), 32'h0);
    chk("rst_press", 32'(btn_press), 32'h0);
    chk_evt("rst", 1'b0, 3'd0, 1'b0);
    rst_n = 1'b1;
    step(1);

    // Clean press on button 2
    btn_raw = 4'b0100;
    step(5);
    chk("clean_lvl5", 32'(btn_level), 32'h0);
    chk("clean_prs5", 32'(btn_press), 32'h0);
    step(1);
    chk("clean_lvl6", 32'(btn_level), 32'h4);
    chk("clean_prs6", 32'(btn_press), 32'h4);
    chk("clean_v6", 32'(evt_if.evt_valid), 32'h0);
    step(1);
    chk("clean_prs7", 32'(btn_press), 32'h0);
    chk_evt("clean_evt", 1'b1, 3'd2, 1'b0);
    evt_if.evt_ack = 1'b1;
    step(1);
    chk("clean_ack", 32'(evt_if.evt_valid), 32'h0);
    step(1);
    chk("idle_ack", 32'(evt_if.evt_valid), 32'h0);
    evt_if.evt_ack = 1'b0;
    btn_raw = 4'b0000;
    step(5);
    chk("rel_lvl5", 32'(btn_level), 32'h4);
    step(1);
    chk("rel_lvl6", 32'(btn_level), 32'h0);
    chk("rel_prs6", 32'(btn_press), 32'h0);

    // Bounce on button 1, then hold
    for (int i = 0; i < 4; i++) begin
      btn_raw = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      step(1);
      chk("bounce_prs", 32'(btn_press), 32'h0);
    end
    btn_raw = 4'b0010;
    step(5);
    chk("bounce_prs5", 32'(btn_press), 32'h0);
    chk("bounce_lvl5", 32'(btn_level), 32'h0);
    step(1);
    chk("bounce_prs6", 32'(btn_press), 32'h2);
    chk("bounce_lvl6", 32'(btn_level), 32'h2);
    step(1);
    chk("bounce_prs7", 32'(btn_press), 32'h0);
    chk_evt("bounce_evt", 1'b1, 3'd1, 1'b0);
    evt_if.evt_ack = 1'b1;
    step(1);
    evt_if.evt_ack = 1'b0;
    chk("bounce_ack", 32'(evt_if.evt_valid), 32'h0);
    btn_raw = 4'b0000;
    step(6);
    chk("bounce_rel", 32'(btn_level), 32'h0);

    // 3-cycle glitch on button 0 is rejected
    btn_raw = 4'b0001;
    step(3);
    btn_raw = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("glitch", {29'd0, |btn_level, |btn_press, evt_if.evt_valid}, 32'h0);
    end

    // Overrun: button 3 pending, button 0 pressed without ack
    btn_raw = 4'b1000;
    step(7);
    chk_evt("ovr_first", 1'b1, 3'd3, 1'b0);
    btn_raw = 4'b1001;
    step(6);
    chk("ovr_prs0", 32'(btn_press), 32'h1);
    step(1);
    chk_evt("ovr_set", 1'b1, 3'd3, 1'b1);
    evt_if.evt_ack = 1'b1;
    step(1);
    evt_if.evt_ack = 1'b0;
    chk_evt("ovr_ack", 1'b0, 3'd3, 1'b0);
    btn_raw = 4'b0000;
    step(6);
    chk("ovr_rel", 32'(btn_level), 32'h0);

    // Simultaneous buttons 1 and 3, then ack coinciding with a press of 2
    btn_raw = 4'b1010;
    step(6);
    chk("sim_prs", 32'(btn_press), 32'hA);
    step(1);
    chk_evt("sim_evt", 1'b1, 3'd1, 1'b1);
    btn_raw = 4'b1110;
    step(6);
    chk("sim_prs2", 32'(btn_press), 32'h4);
    chk_evt("sim_hold", 1'b1, 3'd1, 1'b1);
    evt_if.evt_ack = 1'b1;
    step(1);
    evt_if.evt_ack = 1'b0;
    chk_evt("sim_ackpress", 1'b1, 3'd2, 1'b0);
    step(1);
    chk_evt("sim_keep", 1'b1, 3'd2, 1'b0);
    evt_if.evt_ack = 1'b1;
    step(1);
    evt_if.evt_ack = 1'b0;
    chk_evt("sim_ack", 1'b0, 3'd2, 1'b0);
    btn_raw = 4'b0000;
    step(6);
    chk("sim_rel", 32'(btn_level), 32'h0);

    // Reset while an event is pending and buttons are held
    btn_raw = 4'b0110;
    step(7);
    chk_evt("rst2_pre", 1'b1, 3'd1, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst2_level", 32'(btn_level), 32'h0);
    chk("rst2_press", 32'(btn_press), 32'h0);
    chk_evt("rst2", 1'b0, 3'd0, 1'b0);
    step(2);
    rst_n = 1'b1;
    step(5);
    chk("rst2_lvl5", 32'(btn_level), 32'h0);
    step(1);
    chk("rst2_lvl6", 32'(btn_level), 32'h6);
    chk("rst2_prs6", 32'(btn_press), 32'h6);
    step(1);
    chk_evt("rst2_evt", 1'b1, 3'd1, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
